// File: rtl/pencoder_rr_arbiter.sv
// pencoder_rr_arbiter
//   Shares one 3-bit encoder / 7-segment display path among 8 requesters.
//   A requester is picked in IDLE, holds the display for up to HOLD_CYCLES
//   clocks (or until it drops its request), then a one-cycle GAP precedes
//   the next arbitration.
//
//   Default build: round-robin pick starting at ptr, ptr advances past each
//   requester whose grant ends by release or expiry.
//   `define FIXED_PRIO_EN: ptr is ignored and IDLE picks the highest set
//   request index (bit 7 highest), like the 8:3 priority encoder.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         arbitration enable; low forces idle
//   req[7:0]   request lines
//   grant[7:0] registered one-hot grant, 0 when idle
//   grant_idx  binary index of the granted requester, held when idle
//   seg[6:0]   active-low segments (seg[0]=a .. seg[6]=g), blank when idle
//   flag       busy, always equal to |grant
module pencoder_rr_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic [6:0] seg,
    output logic       flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       grant_nxt;
    logic [2:0]       idx_nxt;
    logic [6:0]       seg_nxt;
    logic             flag_nxt;
    logic [2:0]       pick;

    // Active-low 7-segment pattern for a digit 0..7.
    function automatic logic [6:0] seg_enc(input logic [2:0] d);
        logic [6:0] s;
        case (d)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

`ifdef FIXED_PRIO_EN
    // Highest set index wins: later (higher) hits overwrite earlier ones.
    function automatic logic [2:0] pick_idx(input logic [7:0] r);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) idx = 3'(i);
        end
        return idx;
    endfunction
`else
    // First set bit scanning p, p+1, ... mod 8. The loop runs from the far
    // end backwards so the hit closest to p is the last one written.
    function automatic logic [2:0] pick_idx(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] k;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (r[k]) idx = k;
        end
        return idx;
    endfunction
`endif

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= '0;
            grant     <= 8'h00;
            grant_idx <= 3'd0;
            seg       <= SEG_BLANK;
            flag      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            seg       <= seg_nxt;
            flag      <= flag_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        idx_nxt   = grant_idx;
`ifdef FIXED_PRIO_EN
        pick      = pick_idx(req);
`else
        pick      = pick_idx(req, ptr);
`endif
        case (state)
            IDLE: begin
                grant_nxt = 8'h00;
                if (en && (req != 8'h00)) begin
                    grant_nxt = 8'h01 << pick;
                    idx_nxt   = pick;
                    cnt_nxt   = HOLD_LOAD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!en) begin
                    // Disable aborts the grant without moving the pointer.
                    grant_nxt = 8'h00;
                    state_nxt = IDLE;
                end else if (!req[grant_idx] || (cnt == '0)) begin
                    grant_nxt = 8'h00;
                    ptr_nxt   = grant_idx + 3'd1;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                grant_nxt = 8'h00;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 8'h00;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode, registered alongside grant
    always_comb begin
        flag_nxt = |grant_nxt;
        seg_nxt  = flag_nxt ? seg_enc(idx_nxt) : SEG_BLANK;
    end

endmodule
